instr_fetch: RTL and testbench

- Fetch stage: owns the architectural PC register and issues word reads to instruction memory.
- Buffers returned instructions and hands {inst, inst_pc} to decode over a valid/ready handshake.
- Sits directly upstream of decode and downstream of the next-PC mux; that mux's pc_next arrives here as redirect_pc whenever a jump or taken branch resolves.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/instr_fetch_if.sv | 30 +++
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/instr_fetch.sv | 130 +++++++++++++
 tb/tb_instr_fetch.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Pure declarations; no timing or flow-control behaviour of its own.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          INST_W           = 32;
  localparam logic [INST_W-1:0] NOP_INST   = 32'h0000_0013;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: imem request/response, decode handoff, redirect and fault.
// master = fetch stage, slave = memory/decode/next-PC environment.
interface instr_fetch_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fetch_fault,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fetch_fault,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; head is a registered read, 1-cycle push-to-head.
// Push into a full FIFO and pop from an empty one are ignored; flush overrides both.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int           DEPTH     = 2,
  parameter fetch_entry_t RST_ENTRY = '{pc: RESET_PC_DEFAULT, inst: NOP_INST},
  localparam int          AW        = $clog2(DEPTH),
  localparam int          CW        = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_dat,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Storage is cleared on reset so inst/inst_pc show NOP/RESET_PC before any fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RST_ENTRY;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues in-order word reads, buffers returns for decode (response visible 1 cycle later).
// Issue is throttled so in-flight + buffered never exceeds BUF_DEPTH; decode stalls simply hold the buffer head.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input logic           clk,
  input logic           rst,
  instr_fetch_if.master bus
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  fetch_entry_t  head;
  fetch_entry_t  push_dat;

  logic req_valid;
  logic req_fire;
  logic rsp_seen;
  logic rsp_keep;
  logic push;
  logic inst_fire;
  logic flush;

  // A response only counts against outstanding if one was actually issued.
  assign rsp_seen = bus.imem_rsp_valid && (outstanding_q != '0);
  assign req_fire = req_valid && bus.imem_req_ready;
  assign push     = rsp_keep && !fifo_full;
  assign push_dat = '{pc: rsp_pc_q, inst: bus.imem_rsp_data};

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    req_valid     = 1'b0;
    rsp_keep      = 1'b0;
    inst_fire     = 1'b0;
    flush         = 1'b0;

    case (state_q)
      RUN: begin
        req_valid = !rst && !bus.redirect_valid &&
                    ((int'(outstanding_q) + int'(fifo_count)) < BUF_DEPTH);
        inst_fire = !rst && !fifo_empty && bus.inst_ready;

        if (bus.redirect_valid) begin
          // Everything still in flight belongs to the old path, including a response landing now.
          flush      = 1'b1;
          drop_cnt_d = outstanding_q - CW'(rsp_seen);
          if (misaligned(bus.redirect_pc)) begin
            state_d = HALT;
          end else begin
            fetch_pc_d = bus.redirect_pc;
            rsp_pc_d   = bus.redirect_pc;
          end
        end else begin
          if (rsp_seen) begin
            if (drop_cnt_q != '0) begin
              drop_cnt_d = drop_cnt_q - CW'(1);
            end else begin
              rsp_keep = 1'b1;
              rsp_pc_d = pc_inc(rsp_pc_q);
            end
          end
          if (req_fire) begin
            fetch_pc_d = pc_inc(fetch_pc_q);
          end
        end
      end
      default: begin
        // HALT: nothing issues, nothing reaches decode, late responses fall on the floor.
        flush = 1'b1;
      end
    endcase
  end

  assign outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_seen);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .DEPTH     (BUF_DEPTH),
    .RST_ENTRY ('{pc: RESET_PC, inst: NOP_INST})
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_dat),
    .pop      (inst_fire),
    .flush    (flush),
    .head     (head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.inst_valid     = !rst && (state_q == RUN) && !fifo_empty;
  assign bus.inst           = head.inst;
  assign bus.inst_pc        = head.pc;
  assign bus.fetch_fault    = (state_q == HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: per-cycle vector table plus hand-written redirect/fault/wrap sequences.
`timescale 1ns/1ps
module tb_instr_fetch;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_if bus();

  instr_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // stimulus state applied at the next step
  logic        rst_v;
  logic        mrdy;
  logic        drdy;
  logic        rv;
  logic [31:0] rpc;
  int          lat;
  int          cyc;
  int          nvec;
  int          nfail;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] req_log[$];
  logic [31:0] dlv_pc[$];
  logic [31:0] dlv_inst[$];

  typedef struct {
    logic        r;
    logic        dr;
    logic        chk;
    logic        e_rv;
    logic [31:0] e_ra;
    logic        e_iv;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t tv[$];

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic vec_t mk(input logic r, input logic dr, input logic chk, input logic erv,
                              input logic [31:0] era, input logic eiv, input logic [31:0] eipc);
    vec_t v;
    v.r = r; v.dr = dr; v.chk = chk; v.e_rv = erv; v.e_ra = era; v.e_iv = eiv; v.e_ipc = eipc;
    return v;
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic int qcount(input logic [31:0] q[$], input logic [31:0] val);
    int n = 0;
    foreach (q[i]) if (q[i] == val) n++;
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  // One cycle: drive at negedge, then sample settled outputs and log the handshakes of the coming edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    rst                = rst_v;
    bus.imem_req_ready = mrdy;
    bus.inst_ready     = drdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    if (rst_v) mq.delete();
    if (!rst_v && mq.size() > 0 && mq[0].due == cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mdata(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'hDEAD_BEEF;
    end
    #1;
    if (bus.imem_rsp_valid && dut.u_fifo.full) begin
      nfail++;
      $display("FAIL fifo_overflow: response into full buffer at cycle %0d", cyc);
    end
    if (!rst_v && bus.imem_req_valid && bus.imem_req_ready) begin
      req_log.push_back(bus.imem_req_addr);
      mq.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
    end
    if (!rst_v && bus.inst_valid && bus.inst_ready) begin
      dlv_pc.push_back(bus.inst_pc);
      dlv_inst.push_back(bus.inst);
    end
  endtask

  task automatic do_reset();
    rst_v = 1'b1; rv = 1'b0;
    step();
    step();
    rst_v = 1'b0;
    req_log.delete(); dlv_pc.delete(); dlv_inst.delete();
  endtask

  initial begin
    logic bad;
    nvec = 0; nfail = 0; cyc = 0; lat = 1;
    rst = 1'b1; rst_v = 1'b1; mrdy = 1'b1; drdy = 1'b1; rv = 1'b0; rpc = '0;
    bus.imem_req_ready = 1'b1; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    bus.inst_ready = 1'b1; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;

    // --- per-cycle table, latency 1 ---
    tv.push_back(mk(1, 1, 0, 0, 32'h0,  0, 32'h0));
    tv.push_back(mk(1, 1, 1, 0, 32'h0,  0, 32'h0));
    // streaming, decode always ready: occupancy limit inserts a bubble every third cycle
    tv.push_back(mk(0, 1, 1, 1, 32'h0,  0, 32'h0));
    tv.push_back(mk(0, 1, 1, 1, 32'h4,  0, 32'h0));
    tv.push_back(mk(0, 1, 1, 0, 32'h8,  1, 32'h0));
    tv.push_back(mk(0, 1, 1, 1, 32'h8,  1, 32'h4));
    tv.push_back(mk(0, 1, 1, 1, 32'hC,  0, 32'h0));
    tv.push_back(mk(0, 1, 1, 0, 32'h10, 1, 32'h8));
    tv.push_back(mk(0, 1, 1, 1, 32'h10, 1, 32'hC));
    // reset mid-operation with a request in flight
    tv.push_back(mk(1, 1, 0, 0, 32'h0,  0, 32'h0));
    tv.push_back(mk(1, 1, 1, 0, 32'h0,  0, 32'h0));
    // decode stalled for 10 cycles: exactly two requests, head pinned at pc 0
    tv.push_back(mk(0, 0, 1, 1, 32'h0,  0, 32'h0));
    tv.push_back(mk(0, 0, 1, 1, 32'h4,  0, 32'h0));
    for (int i = 0; i < 8; i++) tv.push_back(mk(0, 0, 1, 0, 32'h8, 1, 32'h0));
    tv.push_back(mk(0, 1, 1, 0, 32'h8,  1, 32'h0));
    tv.push_back(mk(0, 1, 1, 1, 32'h8,  1, 32'h4));
    tv.push_back(mk(0, 1, 1, 1, 32'hC,  0, 32'h0));
    tv.push_back(mk(0, 1, 1, 0, 32'h10, 1, 32'h8));

    foreach (tv[i]) begin
      rst_v = tv[i].r; drdy = tv[i].dr; mrdy = 1'b1; rv = 1'b0;
      step();
      if (tv[i].chk) begin
        nvec++;
        bad = (bus.imem_req_valid !== tv[i].e_rv) || (bus.imem_req_addr !== tv[i].e_ra) ||
              (bus.inst_valid !== tv[i].e_iv) || (bus.fetch_fault !== 1'b0);
        if (tv[i].e_iv)
          bad = bad || (bus.inst_pc !== tv[i].e_ipc) || (bus.inst !== mdata(tv[i].e_ipc));
        if (tv[i].r)
          bad = bad || (bus.inst !== NOP_INST) || (bus.inst_pc !== 32'h0);
        if (bad) begin
          nfail++;
          $display("FAIL vec%0d: got rv=%b ra=%08h iv=%b pc=%08h inst=%08h ff=%b expected rv=%b ra=%08h iv=%b pc=%08h",
                   i, bus.imem_req_valid, bus.imem_req_addr, bus.inst_valid, bus.inst_pc, bus.inst,
                   bus.fetch_fault, tv[i].e_rv, tv[i].e_ra, tv[i].e_iv, tv[i].e_ipc);
        end
      end
    end

    // --- redirect with two requests in flight, latency 3 ---
    do_reset();
    lat = 3; drdy = 1'b1;
    rv = 1'b1; rpc = 32'h10; step();
    check("t3_redir_noreq", {31'b0, bus.imem_req_valid}, 32'h0);
    rv = 1'b0;
    step();
    check("t3_req0", bus.imem_req_addr, 32'h10);
    step();
    check("t3_req1", bus.imem_req_addr, 32'h14);
    rv = 1'b1; rpc = 32'h200; step();
    rv = 1'b0;
    for (int i = 0; i < 15; i++) step();
    check("t3_req_after", qget(req_log, 2), 32'h200);
    check("t3_first_pc", qget(dlv_pc, 0), 32'h200);
    check("t3_first_inst", qget(dlv_inst, 0), mdata(32'h200));
    check("t3_second_pc", qget(dlv_pc, 1), 32'h204);
    check("t3_stale_seen", qcount(dlv_pc, 32'h10) + qcount(dlv_pc, 32'h14), 32'h0);

    // --- redirect coinciding with a response and a decode handshake ---
    do_reset();
    lat = 1; drdy = 1'b1;
    step(); step();
    rv = 1'b1; rpc = 32'h300; step();
    check("t4_iv_at_redir", {31'b0, bus.inst_valid}, 32'h1);
    check("t4_rsp_at_redir", {31'b0, bus.imem_rsp_valid}, 32'h1);
    rv = 1'b0;
    step();
    check("t4_next_req", {bus.imem_req_valid, bus.imem_req_addr[30:0]}, {1'b1, 31'h300});
    for (int i = 0; i < 6; i++) step();
    check("t4_pc0_once", qcount(dlv_pc, 32'h0), 32'h1);
    check("t4_pc4_dropped", qcount(dlv_pc, 32'h4), 32'h0);
    check("t4_after_pc", qget(dlv_pc, 1), 32'h300);
    check("t4_after_inst", qget(dlv_inst, 1), mdata(32'h300));

    // --- misaligned redirect halts until reset ---
    rv = 1'b1; rpc = 32'h102; step();
    check("t5_redir_noreq", {31'b0, bus.imem_req_valid}, 32'h0);
    rv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("t5_halt%0d", i),
            {29'b0, bus.fetch_fault, bus.imem_req_valid, bus.inst_valid}, 32'h4);
    end
    rst_v = 1'b1; step(); step();
    check("t5_fault_cleared", {31'b0, bus.fetch_fault}, 32'h0);
    rst_v = 1'b0; step();
    check("t5_resume", {bus.imem_req_valid, bus.imem_req_addr[30:0]}, {1'b1, 31'h0});

    // --- PC wrap at the top of the address space ---
    do_reset();
    lat = 1; drdy = 1'b1;
    rv = 1'b1; rpc = 32'hFFFF_FFFC; step();
    rv = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("t6_req0", qget(req_log, 0), 32'hFFFF_FFFC);
    check("t6_req1", qget(req_log, 1), 32'h0000_0000);
    check("t6_dlv0", qget(dlv_pc, 0), 32'hFFFF_FFFC);
    check("t6_dlv1", qget(dlv_pc, 1), 32'h0000_0000);
    check("t6_inst1", qget(dlv_inst, 1), mdata(32'h0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
